// File: rtl/fifo_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO arbiter.
// Used by fifo_arbiter (optional counters: FIFO_ARBITER_STATS_EN) and rr_picker.
package fifo_arbiter_pkg;

   typedef enum logic {
      StIdle,
      StBurst
   } state_e;

   // Widest request vector the round-robin helper can scan.
   localparam int unsigned MaxReq  = 32;
   localparam int unsigned MaxReqW = 5;

   // Round-robin pick: first set bit of valid scanning from last_idx+1 upward, modulo num_req.
   // num_req must be a power of two. Returns last_idx when nothing is valid.
   function automatic int unsigned next_rr_index(input logic [MaxReq-1:0] valid,
                                                 input int unsigned       last_idx,
                                                 input int unsigned       num_req);
      int unsigned        pick;
      int unsigned        k;
      logic [MaxReqW-1:0] idx;
      pick = last_idx;
      // Scan farthest candidate first so the nearest valid one is written last and wins.
      for (int unsigned n = 0; n < MaxReq; n++) begin
         k = MaxReq - n;
         if (k <= num_req) begin
            idx = MaxReqW'((last_idx + k) & (num_req - 1));
            if (valid[idx]) begin
               pick = 32'(idx);
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fifo_arbiter_rr_picker.sv
// Combinational round-robin priority selector: valid vector plus last grant gives
// a found flag and the next index to serve.
module rr_picker
   import fifo_arbiter_pkg::*;
#(
   parameter int unsigned  NUM_REQ = 4,
   localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IdxW-1:0]    last,
   output logic               found,
   output logic [IdxW-1:0]    index
);

   logic [MaxReq-1:0] valid_pad;

   // Pad the request vector to the helper width and pick the next requester.
   always_comb begin
      valid_pad = MaxReq'(valid);
      found     = |valid;
      index     = IdxW'(next_rr_index(valid_pad, 32'(last), NUM_REQ));
   end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin, burst-locked arbiter draining NUM_REQ zero-cycle-read FIFOs into one
// registered valid/ready output stage. Optional per-requester saturating word
// counters are built when FIFO_ARBITER_STATS_EN is defined.
module fifo_arbiter
   import fifo_arbiter_pkg::*;
#(
   parameter int unsigned  NUM_REQ       = 4,
   parameter int unsigned  BIT_WIDTH     = 32,
   parameter int unsigned  MAX_BURST     = 4,
   parameter type          METADATA_TYPE = logic,
   localparam int unsigned IdxW          = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_data,
   input  METADATA_TYPE                      req_metadata [NUM_REQ],
   output logic [NUM_REQ-1:0]                req_enable,
   output logic                              out_valid,
   output logic [BIT_WIDTH-1:0]              out_data,
   output METADATA_TYPE                      out_metadata,
   output logic [IdxW-1:0]                   out_source,
   input  logic                              out_ready,
`ifdef FIFO_ARBITER_STATS_EN
   output logic [NUM_REQ-1:0][15:0]          grant_count,
`endif
   output logic                              busy
);

   localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

   state_e          state;
   logic [IdxW-1:0] grant;
   logic [IdxW-1:0] last_grant;
   logic [IdxW-1:0] pick_idx;
   logic [CntW-1:0] burst_cnt;
   logic            pick_found;
   logic            xfer;
   logic            burst_last;

   rr_picker #(
      .NUM_REQ(NUM_REQ)
   ) u_picker (
      .valid(req_valid),
      .last (last_grant),
      .found(pick_found),
      .index(pick_idx)
   );

   // Pop the granted FIFO whenever the output stage is free or being drained this cycle.
   always_comb begin
      xfer              = (state == StBurst) && req_valid[grant] && (!out_valid || out_ready);
      req_enable        = '0;
      req_enable[grant] = xfer;
      burst_last        = (burst_cnt == CntW'(MAX_BURST - 1));
      busy              = (state == StBurst) || out_valid;
   end

   // Arbitration FSM plus the registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= StIdle;
         grant        <= '0;
         last_grant   <= IdxW'(NUM_REQ - 1);
         burst_cnt    <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_metadata <= '0;
         out_source   <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (pick_found) begin
                  grant     <= pick_idx;
                  burst_cnt <= '0;
                  state     <= StBurst;
               end
            end
            StBurst: begin
               // A drained requester or a full burst hands priority to the next one.
               if (!req_valid[grant] || (xfer && burst_last)) begin
                  state      <= StIdle;
                  last_grant <= grant;
               end
               if (xfer) begin
                  burst_cnt <= burst_cnt + CntW'(1);
               end
            end
         endcase

         if (xfer) begin
            out_valid    <= 1'b1;
            out_data     <= req_data[grant];
            out_metadata <= req_metadata[grant];
            out_source   <= grant;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef FIFO_ARBITER_STATS_EN
   // Per-requester saturating count of words popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_count <= '0;
      end else if (xfer && (grant_count[grant] != 16'hFFFF)) begin
         grant_count[grant] <= grant_count[grant] + 16'd1;
      end
   end
`endif

endmodule
